// File: rtl/mem_copy_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine_pkg
//  Description : Shared state encoding and constants for the memory copy /
//                fill engine and its address generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_engine_pkg;

    // Data path word width in bits
    localparam int unsigned WORD_W      = 32;

    // Default byte increment between consecutive words
    localparam int unsigned WORD_STRIDE = 4;

    // Operation select values on the mode input
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Engine states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        FILL   = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage : mem_copy_engine_pkg
`default_nettype wire

// File: rtl/mem_copy_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_addr_gen
//  Description : Working registers for a transfer: current source address,
//                current destination address and remaining word count.
//                The FSM loads them on start and steps them per word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_addr_gen
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned STRIDE = WORD_STRIDE
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              load_i,
    input  logic [WORD_W-1:0] src_i,
    input  logic [WORD_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_src_i,
    input  logic              step_dst_i,
    output logic [WORD_W-1:0] src_cur_o,
    output logic [WORD_W-1:0] dst_cur_o,
    output logic              last_o
);

    localparam logic [WORD_W-1:0] STEP_BYTES = WORD_W'(STRIDE);

    logic [WORD_W-1:0] src_q, src_d;
    logic [WORD_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    // Next values: load on accept, otherwise advance on the FSM's step strobes
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        rem_d = rem_q;
        if (load_i) begin
            src_d = src_i;
            dst_d = dst_i;
            rem_d = len_i;
        end else begin
            if (step_src_i) begin
                src_d = src_q + STEP_BYTES;
            end
            if (step_dst_i) begin
                // A destination step retires one word of the transfer
                dst_d = dst_q + STEP_BYTES;
                rem_d = rem_q - LEN_W'(1);
            end
        end
    end

    // Working register storage
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
        end
    end

    assign src_cur_o = src_q;
    assign dst_cur_o = dst_q;
    assign last_o    = (rem_q == LEN_W'(1));

endmodule : mem_copy_addr_gen
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : RAM-port initiator performing ascending word-block copy
//                (READ/WRITE pairs) or constant word fill, with start/done
//                handshake and abort. RAM outputs are decoded from the
//                state register and working registers only.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned STRIDE = WORD_STRIDE
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              start,
    input  logic              mode,
    input  logic [WORD_W-1:0] src_addr,
    input  logic [WORD_W-1:0] dst_addr,
    input  logic [WORD_W-1:0] fill_data,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] fill_q, fill_d;

    logic              load;
    logic              step_src;
    logic              step_dst;
    logic              last;
    logic [WORD_W-1:0] src_cur;
    logic [WORD_W-1:0] dst_cur;

    mem_copy_addr_gen #(
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) u_addr_gen (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .load_i     (load),
        .src_i      (src_addr),
        .dst_i      (dst_addr),
        .len_i      (len),
        .step_src_i (step_src),
        .step_dst_i (step_dst),
        .src_cur_o  (src_cur),
        .dst_cur_o  (dst_cur),
        .last_o     (last)
    );

    // State, read buffer and fill pattern registers
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state logic and working-register control strobes
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        fill_d   = fill_q;
        load     = 1'b0;
        step_src = 1'b0;
        step_dst = 1'b0;
        case (state_q)
            IDLE: begin
                // start wins over abort here; abort is meaningless when idle
                if (start) begin
                    load   = 1'b1;
                    fill_d = fill_data;
                    if (len == '0) begin
                        state_d = FINISH;
                    end else if (mode == MODE_FILL) begin
                        state_d = FILL;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                buf_d    = mem_rdata;
                step_src = 1'b1;
                state_d  = abort ? IDLE : WRITE;
            end
            WRITE: begin
                // The write driven this cycle lands at the edge even on abort
                step_dst = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = FINISH;
                end else begin
                    state_d = READ;
                end
            end
            FILL: begin
                step_dst = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = FINISH;
                end else begin
                    state_d = FILL;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port and handshake outputs decoded from registered state only
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            READ: begin
                mem_addr = src_cur;
            end
            WRITE: begin
                mem_addr  = dst_cur;
                mem_wdata = buf_q;
                mem_we    = 1'b1;
            end
            FILL: begin
                mem_addr  = dst_cur;
                mem_wdata = fill_q;
                mem_we    = 1'b1;
            end
            default: begin
                mem_addr  = '0;
            end
        endcase
        busy = (state_q != IDLE);
        done = (state_q == FINISH);
    end

endmodule : mem_copy_engine
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_engine
//  Description : Self-checking bench for mem_copy_engine. A 64 KiB word RAM
//                model sits on the engine port; a reference memory image is
//                updated from the copy/fill rules and compared after each
//                operation, along with write sequence, done timing and busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    localparam int WORDS = 16384;

    logic        m_clock;
    logic        p_reset;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] fill_data;
    logic [15:0] len;
    logic        abort;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic        busy;
    logic        done;

    logic [31:0] ram       [0:WORDS-1];
    logic [31:0] model_mem [0:WORDS-1];
    logic [63:0] exp_q     [$];

    int n_chk;
    int n_fail;

    mem_copy_engine #(
        .LEN_W  (16),
        .STRIDE (4)
    ) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .fill_data (fill_data),
        .len       (len),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // RAM model: combinational read, registered write
    assign mem_rdata = ram[mem_addr[15:2]];
    always @(posedge m_clock) begin
        if (mem_we === 1'b1) ram[mem_addr[15:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        ram[addr[15:2]]       = data;
        model_mem[addr[15:2]] = data;
    endtask

    task automatic mem_cmp(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (ram[i] !== model_mem[i]) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr"},  mem_addr,      32'd0);
        chk({tag, "_wdata"}, mem_wdata,     32'd0);
        chk({tag, "_we"},    32'(mem_we),   32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
    endtask

    // One operation: model computes the ordered write list and final image,
    // then the DUT run is observed cycle by cycle after the start edge.
    task automatic run_op(input logic md, input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] fd, input int n, input int abort_k,
                          input int glitch_k);
        int          act, nw, busy_exp, done_exp, cycles;
        int          done_k, done_cnt, we_cnt, busy_cnt;
        bit          aborted;
        logic [31:0] a, d;
        logic [63:0] e;
        int          si, di;

        exp_q.delete();
        act     = md ? n : 2 * n;
        aborted = (abort_k > 0) && (abort_k <= act);
        if (aborted) begin
            nw       = md ? abort_k : abort_k / 2;
            busy_exp = abort_k;
            done_exp = 0;
            cycles   = abort_k + 2;
        end else begin
            nw       = n;
            busy_exp = act;
            done_exp = act + 1;
            cycles   = act + 3;
        end

        // Ascending word-by-word semantics; overlap reads already-written data
        for (int i = 0; i < nw; i++) begin
            a  = dst + 32'(4 * i);
            di = int'(a[15:2]);
            if (md) begin
                d = fd;
            end else begin
                si = int'((src[15:2] + 14'(i)) % 14'(WORDS - 1 + 1));
                si = int'(((src >> 2) + 32'(i)) & 32'(WORDS - 1));
                d  = model_mem[si];
            end
            model_mem[di] = d;
            exp_q.push_back({a, d});
        end

        @(posedge m_clock); #1;
        start     = 1'b1;
        mode      = md;
        src_addr  = src;
        dst_addr  = dst;
        fill_data = fd;
        len       = 16'(n);
        @(posedge m_clock); #1;
        // Scramble inputs after acceptance: the engine must use latched copies
        start     = 1'b0;
        mode      = 1'($urandom);
        src_addr  = $urandom;
        dst_addr  = $urandom;
        fill_data = $urandom;
        len       = 16'($urandom);

        done_k = 0; done_cnt = 0; we_cnt = 0; busy_cnt = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge m_clock);
            abort = 1'b0;
            start = 1'b0;
            if (mem_we === 1'b1) begin
                we_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr,  e[63:32]);
                    chk("wr_data", mem_wdata, e[31:0]);
                end
            end
            if (busy === 1'b1 && done !== 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
                chk("done_busy", 32'(busy), 32'd1);
            end
            if (k == abort_k) abort = 1'b1;
            if (k == glitch_k) start = 1'b1;
        end

        chk("done_cycle",  32'(done_k),   32'(done_exp));
        chk("done_count",  32'(done_cnt), aborted ? 32'd0 : 32'd1);
        chk("we_count",    32'(we_cnt),   32'(nw));
        chk("xfer_busy",   32'(busy_cnt), 32'(busy_exp));
        chk("end_busy",    32'(busy),     32'd0);
        chk("end_we",      32'(mem_we),   32'd0);
        mem_cmp("mem_image");
    endtask

    initial begin
        int          md, n, act, ak;
        logic [31:0] src, dst, fd, v;

        n_chk  = 0;
        n_fail = 0;
        p_reset   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        fill_data = '0;
        len       = '0;
        abort     = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            v = $urandom;
            ram[i]       = v;
            model_mem[i] = v;
        end

        // Reset state
        @(negedge m_clock);
        chk_idle_outputs("reset");
        @(posedge m_clock); #1;
        p_reset = 1'b1;
        @(negedge m_clock);
        chk_idle_outputs("post_reset");

        // Plain copy of four words
        poke(32'h100, 32'h11111111);
        poke(32'h104, 32'h22222222);
        poke(32'h108, 32'h33333333);
        poke(32'h10C, 32'h44444444);
        run_op(1'b0, 32'h100, 32'h200, 32'h0, 4, 0, 0);
        chk("copy_w3", ram[32'h20C >> 2], 32'h44444444);

        // Fill three words; 0x40C must stay as it was
        v = ram[32'h40C >> 2];
        run_op(1'b1, 32'h0, 32'h400, 32'hDEADBEEF, 3, 0, 0);
        chk("fill_w0", ram[32'h400 >> 2], 32'hDEADBEEF);
        chk("fill_untouched", ram[32'h40C >> 2], v);

        // Zero length
        run_op(1'b0, 32'h100, 32'h600, 32'h0, 0, 0, 0);

        // Abort in the third fill cycle, then a fresh start
        run_op(1'b1, 32'h0, 32'h800, 32'h5A5A5A5A, 8, 3, 0);
        run_op(1'b1, 32'h0, 32'hA00, 32'hC0FFEE00, 2, 0, 0);

        // Overlapping forward copy propagates the first word
        poke(32'h000, 32'hAAAA0001);
        poke(32'h004, 32'hBBBB0002);
        poke(32'h008, 32'hCCCC0003);
        run_op(1'b0, 32'h000, 32'h004, 32'h0, 3, 0, 0);
        chk("overlap_w3", ram[32'h00C >> 2], 32'hAAAA0001);

        // Start pulsed mid-transfer must be ignored
        run_op(1'b0, 32'h100, 32'h300, 32'h0, 4, 0, 3);

        // Async reset during a WRITE cycle
        @(posedge m_clock); #1;
        start = 1'b1; mode = 1'b0; src_addr = 32'h200; dst_addr = 32'hC00; len = 16'd4;
        @(posedge m_clock); #1;
        start = 1'b0;
        @(negedge m_clock);
        @(negedge m_clock);
        chk("rst_pre_we", 32'(mem_we), 32'd1);
        #2 p_reset = 1'b0;
        #1 chk_idle_outputs("async_rst");
        @(posedge m_clock); #1;
        p_reset = 1'b1;
        @(negedge m_clock);
        chk_idle_outputs("rst_release");
        mem_cmp("rst_mem");
        run_op(1'b1, 32'h0, 32'hC00, 32'h0BADF00D, 5, 0, 0);

        // Randomized operations, including address wrap and aborts
        for (int t = 0; t < 24; t++) begin
            md  = int'($urandom_range(0, 1));
            n   = int'($urandom_range(0, 12));
            src = $urandom & 32'hFFFF_FFFC;
            dst = (t % 6 == 5) ? (32'hFFFF_FFF0 + ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            fd  = $urandom;
            act = md ? n : 2 * n;
            ak  = (act > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, act)) : 0;
            run_op(md[0], src, dst, fd, n, ak, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_copy_engine
`default_nettype wire
